// File: rtl/wr_fram_pack.sv
// Pixel-to-word packer with an internal word buffer and valid/ready drain port.
// Feeds the DDR write master with packed OUT_W words plus line-end markers.
module wr_fram_pack #(
    parameter int IN_W      = 32,
    parameter int OUT_W     = 128,
    parameter int DEPTH     = 512,
    parameter int BURST_LEN = 16,
    parameter int AW        = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             burst_req,
    output logic [AW:0]      level,
    output logic             overflow
);
    localparam int RATIO = OUT_W / IN_W;
    localparam int LW    = $clog2(RATIO);
    localparam logic [AW:0] LEVEL_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW:0] LEVEL_BURST = (AW+1)'(BURST_LEN);

    logic             clear;
    logic             accept;
    logic             commit;
    logic             pop;
    logic             load;
    logic [LW-1:0]    lane_cnt;
    logic [OUT_W-1:0] pack_reg;
    logic [OUT_W-1:0] word_next;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      ram_cnt;
    logic [AW:0]      tail_cnt;
    logic [OUT_W:0]   mem [DEPTH];

    assign clear     = rst || frame_start;
    assign in_ready  = (level != LEVEL_FULL);
    assign accept    = in_valid && in_ready && !clear;
    assign commit    = accept && ((&lane_cnt) || in_last);
    assign pop       = out_valid && out_ready;
    // ram_cnt tracks words still in RAM, i.e. not yet moved into the output register
    assign load      = (ram_cnt != '0) && (!out_valid || out_ready);
    assign burst_req = (level >= LEVEL_BURST) || (tail_cnt != '0);

    // Lanes above the current one are always zero in pack_reg, which gives line-end padding for free
    always_comb begin
        word_next = pack_reg;
        for (int i = 0; i < RATIO; i++) begin
            if (lane_cnt == LW'(i)) begin
                word_next[i*IN_W +: IN_W] = in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            lane_cnt <= '0;
            pack_reg <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            ram_cnt  <= '0;
            tail_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                lane_cnt <= in_last ? '0 : lane_cnt + 1'b1;
                pack_reg <= commit ? '0 : word_next;
            end
            if (commit) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (load) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level    <= level + (AW+1)'(commit) - (AW+1)'(pop);
            ram_cnt  <= ram_cnt + (AW+1)'(commit) - (AW+1)'(load);
            tail_cnt <= tail_cnt + (AW+1)'(commit && in_last) - (AW+1)'(pop && out_last);
            if (in_valid && !in_ready) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            mem[wr_ptr] <= {in_last, word_next};
        end
    end

    // Synchronous RAM read lands straight in the output register: first-word-fall-through
    always_ff @(posedge clk) begin
        if (clear) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid              <= 1'b1;
            {out_last, out_data}   <= mem[rd_ptr];
        end else if (pop) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_wr_fram_pack.sv
// Directed testbench for wr_fram_pack with hand-computed packed words.
module tb_wr_fram_pack;
    localparam int IN_W  = 32;
    localparam int OUT_W = 128;
    localparam int AW    = 9;

    logic             clk = 1'b0;
    logic             rst;
    logic             frame_start;
    logic             in_valid;
    logic [IN_W-1:0]  in_data;
    logic             in_last;
    logic             in_ready;
    logic             out_valid;
    logic [OUT_W-1:0] out_data;
    logic             out_last;
    logic             out_ready;
    logic             burst_req;
    logic [AW:0]      level;
    logic             overflow;

    int total = 0;
    int bad   = 0;
    logic [OUT_W:0] got_q[$];

    wr_fram_pack #(.IN_W(32), .OUT_W(128), .DEPTH(512), .BURST_LEN(16), .AW(9)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .burst_req(burst_req), .level(level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_valid && out_ready) got_q.push_back({out_last, out_data});
    end

    function automatic logic [OUT_W-1:0] mk4(input logic [31:0] p0, input logic [31:0] p1,
                                             input logic [31:0] p2, input logic [31:0] p3);
        return {p3, p2, p1, p0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push(input logic [31:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; frame_start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        idle(2);
        rst = 1'b0;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        total++; if (out_data !== '0) begin bad++; $display("FAIL rst_out_data got=%h want=0", out_data); end
        total++; if (out_last !== 1'b0) begin bad++; $display("FAIL rst_out_last got=%b want=0", out_last); end
        total++; if (burst_req !== 1'b0) begin bad++; $display("FAIL rst_burst_req got=%b want=0", burst_req); end
        total++; if (level !== 10'd0) begin bad++; $display("FAIL rst_level got=%0d want=0", level); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow got=%b want=0", overflow); end
    endtask

    task automatic test_pack();
        out_ready = 1'b1;
        got_q.delete();
        for (int i = 1; i <= 4; i++) push(32'(i), 1'b0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL pack_lat_n1_valid got=%b want=0", out_valid); end
        total++; if (level !== 10'd1) begin bad++; $display("FAIL pack_lat_n1_level got=%0d want=1", level); end
        total++; if (burst_req !== 1'b0) begin bad++; $display("FAIL pack_burst got=%b want=0", burst_req); end
        push(32'd5, 1'b0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL pack_lat_n2_valid got=%b want=1", out_valid); end
        total++; if (out_data !== mk4(1, 2, 3, 4)) begin bad++; $display("FAIL pack_lat_n2_data got=%h want=%h", out_data, mk4(1, 2, 3, 4)); end
        for (int i = 6; i <= 8; i++) push(32'(i), 1'b0);
        idle(4);
        total++; if (got_q.size() != 2) begin bad++; $display("FAIL pack_count got=%0d want=2", got_q.size()); end
        total++; if (got_q[0] !== {1'b0, mk4(1, 2, 3, 4)}) begin bad++; $display("FAIL pack_word0 got=%h want=%h", got_q[0], {1'b0, mk4(1, 2, 3, 4)}); end
        total++; if (got_q[1] !== {1'b0, mk4(5, 6, 7, 8)}) begin bad++; $display("FAIL pack_word1 got=%h want=%h", got_q[1], {1'b0, mk4(5, 6, 7, 8)}); end
    endtask

    task automatic test_tail();
        out_ready = 1'b0;
        got_q.delete();
        for (int i = 1; i <= 6; i++) push(32'(i), i == 6);
        idle(2);
        total++; if (level !== 10'd2) begin bad++; $display("FAIL tail_level got=%0d want=2", level); end
        total++; if (burst_req !== 1'b1) begin bad++; $display("FAIL tail_burst got=%b want=1", burst_req); end
        total++; if (out_data !== mk4(1, 2, 3, 4) || out_last !== 1'b0) begin bad++; $display("FAIL tail_word0 got=%b_%h want=0_%h", out_last, out_data, mk4(1, 2, 3, 4)); end
        out_ready = 1'b1;
        tick();
        total++; if (out_data !== mk4(5, 6, 0, 0) || out_last !== 1'b1) begin bad++; $display("FAIL tail_word1 got=%b_%h want=1_%h", out_last, out_data, mk4(5, 6, 0, 0)); end
        tick();
        total++; if (burst_req !== 1'b0 || level !== 10'd0) begin bad++; $display("FAIL tail_drained got=burst %b level %0d want=burst 0 level 0", burst_req, level); end
        total++; if (got_q.size() != 2 || got_q[1] !== {1'b1, mk4(5, 6, 0, 0)}) begin bad++; $display("FAIL tail_queue got=%0d words want=2", got_q.size()); end
        got_q.delete();
        for (int i = 9; i <= 12; i++) push(32'(i), i == 12);
        idle(4);
        total++; if (got_q.size() != 1) begin bad++; $display("FAIL last_full_count got=%0d want=1", got_q.size()); end
        total++; if (got_q[0] !== {1'b1, mk4(9, 10, 11, 12)}) begin bad++; $display("FAIL last_full_word got=%h want=%h", got_q[0], {1'b1, mk4(9, 10, 11, 12)}); end
    endtask

    task automatic test_full();
        out_ready = 1'b0;
        got_q.delete();
        for (int i = 0; i < 2048; i++) push(32'(i + 1), 1'b0);
        total++; if (level !== 10'd512) begin bad++; $display("FAIL full_level got=%0d want=512", level); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready got=%b want=0", in_ready); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL full_no_ovf got=%b want=0", overflow); end
        push(32'hDEAD, 1'b0);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL full_ovf got=%b want=1", overflow); end
        total++; if (level !== 10'd512) begin bad++; $display("FAIL full_ovf_level got=%0d want=512", level); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL full_pop_ready got=%b want=1", in_ready); end
        total++; if (level !== 10'd511) begin bad++; $display("FAIL full_pop_level got=%0d want=511", level); end
        total++; if (got_q.size() != 1 || got_q[0] !== {1'b0, mk4(1, 2, 3, 4)}) begin bad++; $display("FAIL full_pop_word got=%h want=%h", got_q[0], {1'b0, mk4(1, 2, 3, 4)}); end
        total++; if (out_data !== mk4(5, 6, 7, 8)) begin bad++; $display("FAIL full_next_word got=%h want=%h", out_data, mk4(5, 6, 7, 8)); end
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        total++; if (level !== 10'd0 || overflow !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL full_clear got=level %0d ovf %b valid %b ready %b want=0 0 0 1", level, overflow, out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int run;
        int errs;
        out_ready = 1'b0;
        got_q.delete();
        for (int w = 0; w < 10; w++)
            for (int l = 0; l < 4; l++) push(32'h200 + 32'(w * 4 + l), 1'b0);
        idle(1);
        out_ready = 1'b1;
        run = 0;
        for (int j = 0; j < 10; j++) begin
            if (out_valid === 1'b1) run++;
            tick();
        end
        total++; if (run != 10) begin bad++; $display("FAIL b2b_run got=%0d want=10", run); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%b want=0", out_valid); end
        errs = (got_q.size() == 10) ? 0 : 1;
        for (int w = 0; w < 10 && w < got_q.size(); w++) begin
            if (got_q[w] !== {1'b0, mk4(32'h200 + 32'(w*4), 32'h201 + 32'(w*4), 32'h202 + 32'(w*4), 32'h203 + 32'(w*4))}) errs++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL b2b_order got=%0d bad words (%0d words) want=0", errs, got_q.size()); end
    endtask

    task automatic test_wrap();
        int maxl;
        int errs;
        logic [31:0] b;
        out_ready = 1'b1;
        got_q.delete();
        maxl = 0;
        for (int i = 0; i < 6144; i++) begin
            push(32'h1000_0000 + 32'(i), 1'b0);
            if (int'(level) > maxl) maxl = int'(level);
        end
        idle(4);
        total++; if (maxl > 2) begin bad++; $display("FAIL wrap_max_level got=%0d want<=2", maxl); end
        total++; if (got_q.size() != 1536) begin bad++; $display("FAIL wrap_count got=%0d want=1536", got_q.size()); end
        errs = 0;
        for (int w = 0; w < 1536 && w < got_q.size(); w++) begin
            b = 32'h1000_0000 + 32'(w * 4);
            if (got_q[w] !== {1'b0, mk4(b, b + 1, b + 2, b + 3)}) errs++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL wrap_order got=%0d bad words want=0", errs); end
    endtask

    task automatic test_frame_start();
        out_ready = 1'b1;
        got_q.delete();
        push(32'h11, 1'b0);
        push(32'h22, 1'b0);
        in_valid = 1'b1; in_data = 32'h33; frame_start = 1'b1;
        tick();
        in_valid = 1'b0; frame_start = 1'b0;
        total++; if (level !== 10'd0 || overflow !== 1'b0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL fs_clear got=level %0d ovf %b valid %b want=0 0 0", level, overflow, out_valid);
        end
        push(32'hAA, 1'b0); push(32'hBB, 1'b0); push(32'hCC, 1'b0); push(32'hDD, 1'b0);
        idle(4);
        total++; if (got_q.size() != 1 || got_q[0] !== {1'b0, mk4(32'hAA, 32'hBB, 32'hCC, 32'hDD)}) begin
            bad++; $display("FAIL fs_word got=%h (%0d words) want=%h", got_q[0], got_q.size(), {1'b0, mk4(32'hAA, 32'hBB, 32'hCC, 32'hDD)});
        end
    endtask

    task automatic test_rst_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 40; i++) push(32'h300 + 32'(i), 1'b0);
        idle(1);
        total++; if (level !== 10'd10) begin bad++; $display("FAIL rstm_level got=%0d want=10", level); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0 ||
                     burst_req !== 1'b0 || level !== 10'd0 || overflow !== 1'b0) begin
            bad++; $display("FAIL rstm_outputs got=rdy %b val %b data %h last %b burst %b level %0d ovf %b want=1 0 0 0 0 0 0",
                            in_ready, out_valid, out_data, out_last, burst_req, level, overflow);
        end
        out_ready = 1'b1;
        got_q.delete();
        for (int i = 0; i < 4; i++) push(32'h51 + 32'(i), 1'b0);
        idle(4);
        total++; if (got_q.size() != 1 || got_q[0] !== {1'b0, mk4(32'h51, 32'h52, 32'h53, 32'h54)}) begin
            bad++; $display("FAIL rstm_word got=%h (%0d words) want=%h", got_q[0], got_q.size(), {1'b0, mk4(32'h51, 32'h52, 32'h53, 32'h54)});
        end
    endtask

    initial begin
        test_reset();
        test_pack();
        test_tail();
        test_full();
        test_back_to_back();
        test_wrap();
        test_frame_start();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
